// File: rtl/pong_pkg.sv
// Shared definitions for the pong game sequencer: state codes, text-region masks
// and the two-digit BCD increment used by both the score counters and the win check.
package pong_pkg;

    localparam int DIG_W = 4;

    localparam logic [1:0] ST_NEWGAME = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_NEWBALL = 2'd2;
    localparam logic [1:0] ST_OVER    = 2'd3;

    localparam logic [3:0] TEXT_SCORE = 4'b1000;
    localparam logic [3:0] TEXT_LOGO  = 4'b0100;
    localparam logic [3:0] TEXT_RULE  = 4'b0010;
    localparam logic [3:0] TEXT_OVER  = 4'b0001;

    // Ones wrap 9->0 with carry; tens stop at 9, so 99 stays 99.
    function automatic logic [2*DIG_W-1:0] bcd2_inc(input logic [2*DIG_W-1:0] v);
        logic [DIG_W-1:0] ones;
        logic [DIG_W-1:0] tens;
        ones = v[DIG_W-1:0];
        tens = v[2*DIG_W-1:DIG_W];
        if (ones != DIG_W'(9)) begin
            ones = ones + DIG_W'(1);
        end else if (tens != DIG_W'(9)) begin
            ones = '0;
            tens = tens + DIG_W'(1);
        end
        return {tens, ones};
    endfunction

    function automatic logic [3:0] text_for(input logic [1:0] st);
        logic [3:0] t;
        case (st)
            ST_NEWGAME: t = TEXT_SCORE | TEXT_LOGO | TEXT_RULE;
            ST_OVER:    t = TEXT_SCORE | TEXT_LOGO | TEXT_OVER;
            default:    t = TEXT_SCORE | TEXT_LOGO;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pong_bcd2_cnt.sv
// Two-digit BCD score counter with synchronous clear and a saturating tens digit.
module pong_bcd2_cnt
    import pong_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [DIG_W-1:0] dig0,
    output logic [DIG_W-1:0] dig1
);

    // Clear has priority so a new game always starts from 00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig0 <= '0;
            dig1 <= '0;
        end else if (clr) begin
            dig0 <= '0;
            dig1 <= '0;
        end else if (inc) begin
            {dig1, dig0} <= bcd2_inc({dig1, dig0});
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Two-player pong game sequencer: scores, balls remaining, pause timer and the
// newgame/play/newball/over state machine driving text overlay and graphics freeze.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter logic [7:0] WIN_SCORE   = 8'h11,
    parameter logic [1:0] BALLS       = 2'd3,
    parameter int         WAIT_FRAMES = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refr_tick,
    input  logic [3:0]       btn,
    input  logic             miss_a,
    input  logic             miss_b,
    output logic             graph_still,
    output logic             ball_rst,
    output logic [1:0]       ball,
    output logic [DIG_W-1:0] dig0_A,
    output logic [DIG_W-1:0] dig1_A,
    output logic [DIG_W-1:0] dig0_B,
    output logic [DIG_W-1:0] dig1_B,
    output logic [3:0]       text_en
);

    localparam int TW = (WAIT_FRAMES < 2) ? 1 : $clog2(WAIT_FRAMES + 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [1:0]    ball_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          rst_nxt;
    logic          clr;
    logic          inc_a;
    logic          inc_b;
    logic          pressed;
    logic          missed;
    logic          win;

    assign pressed = (btn != 4'd0);
    assign missed  = miss_a | miss_b;

    pong_bcd2_cnt u_score_a (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (inc_a),
        .dig0  (dig0_A),
        .dig1  (dig1_A)
    );

    pong_bcd2_cnt u_score_b (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (inc_b),
        .dig0  (dig0_B),
        .dig1  (dig1_B)
    );

    // Win is judged on the score as it will be after this miss, not the stale register;
    // miss_a takes precedence so only B can score when both pulses arrive together.
    always_comb begin
        if (miss_a) begin
            win = (bcd2_inc({dig1_B, dig0_B}) == WIN_SCORE);
        end else begin
            win = (bcd2_inc({dig1_A, dig0_A}) == WIN_SCORE);
        end
    end

    always_comb begin
        state_nxt = state;
        ball_nxt  = ball;
        timer_nxt = timer;
        rst_nxt   = 1'b0;
        clr       = 1'b0;
        inc_a     = 1'b0;
        inc_b     = 1'b0;

        if ((state == ST_NEWBALL || state == ST_OVER) && refr_tick && timer != '0) begin
            timer_nxt = timer - TW'(1);
        end

        case (state)
            ST_NEWGAME: begin
                if (pressed) begin
                    state_nxt = ST_PLAY;
                    clr       = 1'b1;
                    ball_nxt  = BALLS;
                    rst_nxt   = 1'b1;
                end
            end
            ST_PLAY: begin
                if (missed) begin
                    inc_b     = miss_a;
                    inc_a     = ~miss_a;
                    ball_nxt  = (ball != 2'd0) ? ball - 2'd1 : 2'd0;
                    timer_nxt = TW'(WAIT_FRAMES);
                    if (win || ball_nxt == 2'd0) begin
                        state_nxt = ST_OVER;
                    end else begin
                        state_nxt = ST_NEWBALL;
                    end
                end
            end
            ST_NEWBALL: begin
                if (timer == '0 && pressed) begin
                    state_nxt = ST_PLAY;
                    rst_nxt   = 1'b1;
                end
            end
            default: begin
                if (timer == '0) begin
                    state_nxt = ST_NEWGAME;
                end
            end
        endcase
    end

    // Presentation outputs follow the next state so they change on the same edge as state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_NEWGAME;
            ball        <= BALLS;
            timer       <= '0;
            graph_still <= 1'b1;
            ball_rst    <= 1'b0;
            text_en     <= text_for(ST_NEWGAME);
        end else begin
            state       <= state_nxt;
            ball        <= ball_nxt;
            timer       <= timer_nxt;
            graph_still <= (state_nxt != ST_PLAY);
            ball_rst    <= rst_nxt;
            text_en     <= text_for(state_nxt);
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed game scenarios plus random play,
// compared against a score/ball/pause model of the game rules.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       refr_tick;
    logic [3:0] btn;
    logic       miss_a;
    logic       miss_b;

    logic       still0, brst0, still1, brst1;
    logic [1:0] ball0, ball1;
    logic [3:0] d0a0, d1a0, d0b0, d1b0, ten0;
    logic [3:0] d0a1, d1a1, d0b1, d1b1, ten1;

    logic       cnt_clr, cnt_inc;
    logic [3:0] cd0, cd1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int st;
        int sa;
        int sb;
        int ball;
        int timer;
        int brst;
    } model_t;

    model_t m0, m1;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk(clk), .reset(reset), .refr_tick(refr_tick), .btn(btn),
        .miss_a(miss_a), .miss_b(miss_b), .graph_still(still0), .ball_rst(brst0),
        .ball(ball0), .dig0_A(d0a0), .dig1_A(d1a0), .dig0_B(d0b0), .dig1_B(d1b0),
        .text_en(ten0)
    );

    pong_game_ctrl #(.WIN_SCORE(8'h02), .BALLS(2'd3), .WAIT_FRAMES(3)) dut_w (
        .clk(clk), .reset(reset), .refr_tick(refr_tick), .btn(btn),
        .miss_a(miss_a), .miss_b(miss_b), .graph_still(still1), .ball_rst(brst1),
        .ball(ball1), .dig0_A(d0a1), .dig1_A(d1a1), .dig0_B(d0b1), .dig1_B(d1b1),
        .text_en(ten1)
    );

    pong_bcd2_cnt u_cnt (
        .clk(clk), .reset(reset), .clr(cnt_clr), .inc(cnt_inc), .dig0(cd0), .dig1(cd1)
    );

    // Model states: 0 newgame, 1 play, 2 newball, 3 over; scores held as plain integers.
    function automatic model_t model_reset(int balls);
        model_t m;
        m.st = 0; m.sa = 0; m.sb = 0; m.ball = balls; m.timer = 0; m.brst = 0;
        return m;
    endfunction

    function automatic model_t model_next(model_t m, int win, int balls, int waitf,
                                          int b, int ma, int mb, int tk);
        model_t n;
        int scorer;
        n = m;
        n.brst = 0;
        if (m.st == 0) begin
            if (b != 0) begin
                n.st = 1; n.sa = 0; n.sb = 0; n.ball = balls; n.brst = 1;
            end
        end else if (m.st == 1) begin
            if (ma != 0 || mb != 0) begin
                if (ma != 0) begin
                    n.sb = (m.sb < 99) ? m.sb + 1 : 99;
                    scorer = n.sb;
                end else begin
                    n.sa = (m.sa < 99) ? m.sa + 1 : 99;
                    scorer = n.sa;
                end
                n.ball = (m.ball > 0) ? m.ball - 1 : 0;
                n.timer = waitf;
                n.st = (scorer == win || n.ball == 0) ? 3 : 2;
            end
        end else if (m.st == 2) begin
            if (m.timer == 0 && b != 0) begin
                n.st = 1; n.brst = 1;
            end else if (tk != 0 && m.timer > 0) begin
                n.timer = m.timer - 1;
            end
        end else begin
            if (m.timer == 0) n.st = 0;
            else if (tk != 0) n.timer = m.timer - 1;
        end
        return n;
    endfunction

    function automatic int text_of(int st);
        case (st)
            0: return 14;
            3: return 13;
            default: return 12;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic check_model(input string who, input model_t m, input int still, input int brst,
                               input int bl, input int d0a, input int d1a, input int d0b,
                               input int d1b, input int ten);
        checkOutput({who, ".still"}, still, (m.st != 1) ? 1 : 0);
        checkOutput({who, ".ball_rst"}, brst, m.brst);
        checkOutput({who, ".ball"}, bl, m.ball);
        checkOutput({who, ".dig0_A"}, d0a, m.sa % 10);
        checkOutput({who, ".dig1_A"}, d1a, m.sa / 10);
        checkOutput({who, ".dig0_B"}, d0b, m.sb % 10);
        checkOutput({who, ".dig1_B"}, d1b, m.sb / 10);
        checkOutput({who, ".text_en"}, ten, text_of(m.st));
    endtask

    task automatic check_both();
        check_model("main", m0, still0, brst0, ball0, d0a0, d1a0, d0b0, d1b0, ten0);
        check_model("win", m1, still1, brst1, ball1, d0a1, d1a1, d0b1, d1b1, ten1);
    endtask

    task automatic applyStimulus(input logic [3:0] b, input logic ma, input logic mb,
                                 input logic tk);
        btn = b; miss_a = ma; miss_b = mb; refr_tick = tk;
        @(posedge clk);
        m0 = model_next(m0, 11, 3, 120, b, ma, mb, tk);
        m1 = model_next(m1, 2, 3, 3, b, ma, mb, tk);
        #1;
        check_both();
    endtask

    task automatic run_frames(input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) applyStimulus(b, 1'b0, 1'b0, j == 0);
        end
    endtask

    initial begin
        logic [3:0] rb;
        int e;
        reset = 1'b1; btn = '0; miss_a = 0; miss_b = 0; refr_tick = 0;
        cnt_clr = 0; cnt_inc = 0;
        repeat (3) @(posedge clk);
        #1;
        m0 = model_reset(3);
        m1 = model_reset(3);
        check_both();
        @(negedge clk);
        reset = 1'b0;

        // BCD counter on its own: carry 09->10 and saturation at 99.
        cnt_inc = 1'b1;
        for (int i = 1; i <= 101; i++) begin
            @(posedge clk);
            #1;
            e = (i < 99) ? i : 99;
            checkOutput("cnt.value", int'({cd1, cd0}), (e / 10) * 16 + (e % 10));
        end
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("cnt.clear", int'({cd1, cd0}), 0);
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;

        run_frames(10, 4'b0000);
        applyStimulus(4'b0001, 0, 0, 0);
        applyStimulus(4'b0000, 0, 0, 0);
        applyStimulus(4'b0000, 1, 0, 0);
        run_frames(60, 4'b0010);
        run_frames(61, 4'b0010);
        applyStimulus(4'b0000, 1, 1, 1);
        applyStimulus(4'b0000, 0, 1, 0);
        run_frames(121, 4'b1000);
        applyStimulus(4'b0000, 1, 0, 0);
        run_frames(50, 4'b0000);
        checkOutput("main.over_text", ten0, 13);
        run_frames(71, 4'b0000);
        checkOutput("main.newgame_text", ten0, 14);
        applyStimulus(4'b0100, 0, 0, 0);
        applyStimulus(4'b0000, 0, 1, 0);
        run_frames(121, 4'b0001);
        applyStimulus(4'b0000, 0, 1, 0);
        checkOutput("win.over_text", ten1, 13);
        run_frames(10, 4'b0000);

        // Asynchronous reset in the middle of a pause.
        #2;
        reset = 1'b1;
        #1;
        m0 = model_reset(3);
        m1 = model_reset(3);
        check_both();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6000; i++) begin
            rb = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            applyStimulus(rb, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, (i % 4) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
